// File: rtl/ifetch_queue.sv
// Instruction fetch queue: a PC register drives a combinational ROM, and fetched
// {pc, instr} pairs go into a small circular buffer that decode drains.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  output logic [31:0]              rom_addr,
  input  logic [31:0]              rom_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic          pop;
  logic          push;

  assign rom_addr  = pc_q;
  assign count     = count_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = pc_mem_q[head_q];
  assign out_instr = instr_mem_q[head_q];

  // Valid/ready: an entry leaves when out_valid & out_ready at a rising edge,
  // unless a redirect flushes the queue in that same cycle.
  assign pop  = out_valid & out_ready & ~redirect_valid;
  assign push = fetch_en & ~redirect_valid & ((count_q < FULL) | pop);

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d   = pc_q + 32'd4;
        tail_d = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only entries covered by count are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q]    <= pc_q;
      instr_mem_q[tail_q] <= rom_data;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: a queue-level reference model predicts fetched
// entries; a monitor compares the DUT head, count, valid and PC every cycle.
module tb_ifetch_queue;

  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH    = 2;

  logic                    clk;
  logic                    rst;
  logic                    fetch_en;
  logic [31:0]             rom_addr;
  logic [31:0]             rom_data;
  logic                    redirect_valid;
  logic [31:0]             redirect_pc;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_pc;
  logic [31:0]             out_instr;
  logic [$clog2(DEPTH):0]  count;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] model_pc;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_instr_q[$];

  ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .count          (count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word i holds i+1
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return (addr >> 2) + 32'd1;
  endfunction

  assign rom_data = rom_word(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: acts on the inputs of the cycle, after the monitor has popped
  task automatic model_step();
    if (rst) begin
      exp_pc_q.delete();
      exp_instr_q.delete();
      model_pc = RESET_PC;
    end else if (redirect_valid) begin
      exp_pc_q.delete();
      exp_instr_q.delete();
      model_pc = redirect_pc & 32'hFFFF_FFFC;
    end else if (fetch_en && exp_pc_q.size() < DEPTH) begin
      exp_pc_q.push_back(model_pc);
      exp_instr_q.push_back(rom_word(model_pc));
      model_pc = model_pc + 32'd4;
    end
  endtask

  // driver task: one cycle of stimulus, applied on the falling edge
  task automatic cyc(input logic r, input logic fe, input logic rdy,
                     input logic rv, input logic [31:0] rp);
    @(negedge clk);
    rst            = r;
    fetch_en       = fe;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    #2;
    model_step();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      check("rom_addr", rom_addr, model_pc);
      check("count", 32'(count), 32'(exp_pc_q.size()));
      check("out_valid", 32'(out_valid), 32'(exp_pc_q.size() != 0));
      if (exp_pc_q.size() != 0) begin
        check("out_pc", out_pc, exp_pc_q[0]);
        check("out_instr", out_instr, exp_instr_q[0]);
        if (out_ready) begin
          void'(exp_pc_q.pop_front());
          void'(exp_instr_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    fetch_en = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    // free run across the 32-bit PC wrap
    repeat (6) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    // restart at 0, free run with no bubbles
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
    repeat (8) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    // stall decode from a fresh start: queue fills, head held
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    repeat (5) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (4) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    // flush a full queue with a misaligned target
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0102);
    repeat (4) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    // drain with fetch disabled
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    // reset beats redirect with one entry queued
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0200);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0400);
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : $urandom();
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 19) == 0),
          rp);
    end

    @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 Parameter DEPTH, default 2, the number of queue entries (legal values: 2 or 4).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fetch_en  input  1  while high, the block may issue new fetches.
REQ-006 rom_addr  output  32  byte address to the instruction ROM; equals the current PC.
REQ-007 rom_data  input  32  instruction word returned combinationally by the ROM for rom_addr in the same cycle.
REQ-008 redirect_valid  input  1  branch/jump/flush request from execute.
REQ-009 redirect_pc  input  32  target byte address for the redirect.
REQ-010 out_valid  output  1  the queue head holds a valid instruction.
REQ-011 out_ready  input  1  decode accepts the head this cycle.
REQ-012 out_pc  output  32  PC of the head entry.
REQ-013 out_instr  output  32  instruction word of the head entry.
REQ-014 count  output  $clog2(DEPTH)+1  current number of occupied entries.

Function
REQ-015 The block SHALL hold a 32-bit PC register and drive rom_addr = pc combinationally.
REQ-016 push = fetch_en & ~redirect_valid & (count < DEPTH | pop), where pop = out_valid & out_ready.
REQ-017 On push, {pc, rom_data} SHALL be written at the tail and pc SHALL advance by 4.
- Advance is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-018 On pop, the head SHALL advance.
- Head and tail pointers SHALL wrap modulo DEPTH.
REQ-019 count next = count + push - pop; simultaneous push and pop SHALL leave count unchanged.
- Push and pop in the same cycle are legal when the queue is full.
REQ-020 out_valid = (count != 0); out_pc and out_instr SHALL come from the head entry with no extra register stage.
- Output latency is 1 cycle from the rising edge on which the entry was fetched.
REQ-021 While out_valid & ~out_ready, out_pc and out_instr SHALL stay stable.
REQ-022 On redirect_valid:
- the queue SHALL be flushed: count = 0, pointers = 0, out_valid low next cycle;
- pc SHALL load {redirect_pc[31:2], 2'b00};
- no push occurs that cycle;
- any pop that cycle SHALL be ignored.
REQ-023 Redirect SHALL take priority over push, pop and fetch_en.
- Fetching SHALL resume from the new PC on the following cycle if fetch_en is high.
REQ-024 With fetch_en low, pc SHALL hold and no push SHALL occur.
- Pops continue, so the queue drains.
REQ-025 Fetch bandwidth is at most one instruction per cycle; an empty queue with out_ready high SHALL see no bubble after the first fill.
REQ-026 Stored entry contents are don't-care when not valid; only entries counted by count are observable.

Reset
REQ-027 When rst is high at a rising edge, the block SHALL load:
- pc = RESET_PC;
- count = 0;
- head and tail pointers = 0.
REQ-028 After reset, out_valid = 0; out_pc and out_instr are don't-care while out_valid is 0.
REQ-029 Reset SHALL override redirect, push and pop in the same cycle.
- Reset asserted mid-stream SHALL discard all queued entries.

Verification
REQ-030 Reset, then fetch_en=1 and out_ready=1, with ROM[i] = i+1 -> output sequence:
- cycle 1: out_pc=0, out_instr=1;
- cycle 2: out_pc=4, out_instr=2;
- continues one entry per cycle with no bubbles.
REQ-031 out_ready=0 for 5 cycles with fetch_en=1 (DEPTH=2) -> count=2 and rom_addr holds 8; out_pc=0 held stable; releasing out_ready -> pc 0,4,8 in order.
REQ-032 Full queue with out_ready=1 and fetch_en=1 -> count stays 2 and one entry moves in and one out per cycle.
REQ-033 redirect_valid with redirect_pc=32'h0000_0102 while count=2 -> out_valid=0 next cycle, then out_pc=32'h0000_0100.
REQ-034 RESET_PC=32'hFFFF_FFF8, free run -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 rst asserted in the same cycle as redirect_valid, with count=1 -> next cycle pc=RESET_PC, count=0, out_valid=0.
